// File: rtl/subtracter_pkg.sv
// Shared definitions for the bit-serial subtracter: FSM state encoding and default width.
package subtracter_pkg;

    localparam int DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } state_e;

endpackage

// File: rtl/full_subtracter_cell.sv
// Full-subtracter cell (a - b - bin) built from two gate-level half subtracters.
module half_subtracter (
    input  logic x_i,
    input  logic y_i,
    output logic d_o,
    output logic bo_o
);
    assign d_o  = x_i ^ y_i;
    assign bo_o = ~x_i & y_i;
endmodule

module full_subtracter_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic bin_i,
    output logic d_o,
    output logic bout_o
);
    logic d1, bo1, bo2;

    half_subtracter u_hs_ab  (.x_i(a_i), .y_i(b_i),   .d_o(d1),  .bo_o(bo1));
    half_subtracter u_hs_bin (.x_i(d1),  .y_i(bin_i), .d_o(d_o), .bo_o(bo2));

    // A borrow can come from either stage but never from both at once.
    assign bout_o = bo1 | bo2;
endmodule

// File: rtl/serial_subtracter.sv
// Bit-serial a - b, LSB first: one full-subtracter cell plus a borrow flop, WIDTH+1 cycles per result.
module serial_subtracter
    import subtracter_pkg::*;
#(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             barrow
);
    localparam int CW = $clog2(WIDTH + 1);

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_q, a_d, b_q, b_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
    logic             barrow_q, barrow_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             cell_d, cell_bout;
    logic [WIDTH-1:0] res_shifted;

    full_subtracter_cell u_cell (
        .a_i   (a_q[0]),
        .b_i   (b_q[0]),
        .bin_i (borrow_q),
        .d_o   (cell_d),
        .bout_o(cell_bout)
    );

    assign res_shifted = {cell_d, res_q[WIDTH-1:1]};

    // NOTE: every signal gets its hold value first so no path through the case infers a latch.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        res_d    = res_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
        barrow_d = barrow_q;
        cnt_d    = cnt_q;

        unique case (state_q)
            IDLE, DONE: begin
                state_d = IDLE;
                if (start) begin
                    a_d      = a;
                    b_d      = b;
                    res_d    = '0;
                    borrow_d = 1'b0;
                    cnt_d    = '0;
                    state_d  = SHIFT;
                end
            end
            SHIFT: begin
                a_d      = a_q >> 1;
                b_d      = b_q >> 1;
                res_d    = res_shifted;
                borrow_d = cell_bout;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    diff_d   = res_shifted;
                    barrow_d = cell_bout;
                    state_d  = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update from pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
            barrow_q <= 1'b0;
            cnt_q    <= '0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            res_q    <= res_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
            barrow_q <= barrow_d;
            cnt_q    <= cnt_d;
        end
    end

    assign busy   = (state_q == SHIFT);
    assign done   = (state_q == DONE);
    assign diff   = diff_q;
    assign barrow = barrow_q;

endmodule

// File: tb/tb_serial_subtracter.sv
// Self-checking bench for serial_subtracter: directed and random operands against an arithmetic model.
module tb_serial_subtracter;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, barrow;
    logic [W-1:0] diff;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    serial_subtracter #(.WIDTH(W)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .start (start),
        .a     (a),
        .b     (b),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .barrow(barrow)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    // Reference: unsigned modulo subtraction; borrow is simply a < b.
    function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
        return x - y;
    endfunction

    function automatic logic model_borrow(input logic [W-1:0] x, input logic [W-1:0] y);
        return x < y;
    endfunction

    task automatic check_outputs(input string name, input logic [W-1:0] exp_d, input logic exp_b);
        checks++;
        if (diff !== exp_d) begin
            errors++;
            $display("FAIL %s diff: got %h expected %h", name, diff, exp_d);
        end
        checks++;
        if (barrow !== exp_b) begin
            errors++;
            $display("FAIL %s barrow: got %b expected %b", name, barrow, exp_b);
        end
    endtask

    // One complete transaction: pulse start, verify latency, busy span, result hold, and the result.
    task automatic run_op(input logic [W-1:0] av, input logic [W-1:0] bv, input string name);
        int           lat;
        int           busy_cnt;
        logic         hold_ok;
        logic         overlap;
        logic [W-1:0] prev_d;
        logic         prev_b;
        @(negedge clk);
        prev_d = diff;
        prev_b = barrow;
        a = av;
        b = bv;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        a = ~av;
        b = ~bv;
        lat = 1;
        busy_cnt = 0;
        hold_ok = 1'b1;
        overlap = 1'b0;
        while (done !== 1'b1 && lat < 40) begin
            if (busy === 1'b1) busy_cnt++;
            if (diff !== prev_d || barrow !== prev_b) hold_ok = 1'b0;
            @(negedge clk);
            lat++;
        end
        if (busy === 1'b1 && done === 1'b1) overlap = 1'b1;
        checks++;
        if (lat != W + 1) begin
            errors++;
            $display("FAIL %s latency: got %0d expected %0d", name, lat, W + 1);
        end
        checks++;
        if (busy_cnt != W) begin
            errors++;
            $display("FAIL %s busy_cycles: got %0d expected %0d", name, busy_cnt, W);
        end
        checks++;
        if (!hold_ok) begin
            errors++;
            $display("FAIL %s hold: result changed while busy, prev %h/%b", name, prev_d, prev_b);
        end
        checks++;
        if (overlap) begin
            errors++;
            $display("FAIL %s busy_done_overlap: got 1 expected 0", name);
        end
        check_outputs(name, model_diff(av, bv), model_borrow(av, bv));
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: got done=%b busy=%b expected 0/0", name, done, busy);
        end
    endtask

    task automatic test_reset;
        #1 rst_n = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset busy_done: got %b expected 00", {busy, done});
        end
        check_outputs("reset", '0, 1'b0);
        rst_n = 1'b1;
    endtask

    task automatic test_directed;
        run_op(8'h5A, 8'h23, "dir_5a_23");
        run_op(8'h23, 8'h5A, "dir_23_5a");
        run_op(8'h00, 8'h01, "dir_00_01");
        run_op(8'hFF, 8'hFF, "dir_ff_ff");
        run_op(8'h00, 8'h00, "dir_00_00");
        run_op(8'h00, 8'hFF, "dir_00_ff");
    endtask

    task automatic test_random;
        for (int i = 0; i < 20; i++) begin
            run_op(W'($urandom), W'($urandom), $sformatf("rand_%0d", i));
        end
    endtask

    task automatic test_ignore_start;
        int           dones;
        logic [W-1:0] got_d;
        logic         got_b;
        @(negedge clk);
        a = 8'h5A;
        b = 8'h23;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (2) @(negedge clk);
        a = 8'h10;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        dones = 0;
        got_d = '0;
        got_b = 1'b0;
        for (int i = 0; i < 20; i++) begin
            if (done === 1'b1) begin
                dones++;
                got_d = diff;
                got_b = barrow;
            end
            @(negedge clk);
        end
        checks++;
        if (dones != 1) begin
            errors++;
            $display("FAIL ignore_start done_count: got %0d expected 1", dones);
        end
        checks++;
        if (got_d !== model_diff(8'h5A, 8'h23) || got_b !== model_borrow(8'h5A, 8'h23)) begin
            errors++;
            $display("FAIL ignore_start result: got %h/%b expected %h/%b", got_d, got_b,
                     model_diff(8'h5A, 8'h23), model_borrow(8'h5A, 8'h23));
        end
    endtask

    task automatic test_back_to_back;
        int t1, t2, n;
        @(negedge clk);
        a = 8'h80;
        b = 8'h01;
        start = 1'b1;
        @(negedge clk);
        a = 8'h01;
        b = 8'h80;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        t1 = cyc;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b first_done: got %b expected 1", done);
        end
        check_outputs("b2b_first", model_diff(8'h80, 8'h01), model_borrow(8'h80, 8'h01));
        @(negedge clk);
        start = 1'b0;
        n = 0;
        while (done !== 1'b1 && n < 40) begin
            @(negedge clk);
            n++;
        end
        t2 = cyc;
        checks++;
        if (done !== 1'b1) begin
            errors++;
            $display("FAIL b2b second_done: got %b expected 1", done);
        end
        check_outputs("b2b_second", model_diff(8'h01, 8'h80), model_borrow(8'h01, 8'h80));
        checks++;
        if (t2 - t1 != W + 1) begin
            errors++;
            $display("FAIL b2b spacing: got %0d expected %0d", t2 - t1, W + 1);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int dones;
        @(negedge clk);
        a = 8'h23;
        b = 8'h5A;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if ({busy, done} !== 2'b00) begin
            errors++;
            $display("FAIL reset_mid busy_done: got %b expected 00", {busy, done});
        end
        check_outputs("reset_mid", '0, 1'b0);
        dones = 0;
        repeat (2) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        rst_n = 1'b1;
        repeat (12) begin
            @(negedge clk);
            if (done === 1'b1) dones++;
        end
        checks++;
        if (dones != 0) begin
            errors++;
            $display("FAIL reset_mid spurious_done: got %0d expected 0", dones);
        end
        run_op(8'h0F, 8'h0E, "after_reset");
    endtask

    initial begin
        test_reset;
        test_directed;
        test_ignore_start;
        test_back_to_back;
        test_random;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
